apb4_gpio_seq: RTL

APB4-programmable pattern sequencer that drives GPIO pins from a table of timed steps. It sits beside `apb4_gpio` and feeds that block's alternate-function path: `seq_out_o`/`seq_oe_o` go to pins whose IOF bit is set. Software loads up to STEP_NUM (value, hold) pairs, then starts a one-shot or looping playback. Completion raises an interrupt.

---
 rtl/apb4_gpio_seq_pkg.sv | 50 +++++
 rtl/apb4_if.sv | 29 ++
 rtl/apb4_gpio_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_gpio_seq_pkg.sv
// Shared definitions for the APB4 GPIO pattern sequencer: register offsets,
// control/status bit positions, FSM state encoding and the step record.
package apb4_gpio_seq_pkg;

  // Register select values, compared against paddr[5:2]
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_MASK   = 4'h2;
  localparam logic [3:0] REG_LAST   = 4'h3;
  localparam logic [3:0] REG_IDX    = 4'h4;
  localparam logic [3:0] REG_VAL    = 4'h5;
  localparam logic [3:0] REG_HOLD   = 4'h6;

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_IRQEN = 3;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  // Widest supported hold field; narrower configurations keep the upper bits zero
  localparam int HOLD_WIDTH_MAX = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // One table entry: pattern value and the extra cycles it is held for
  typedef struct packed {
    logic [31:0]               val;
    logic [HOLD_WIDTH_MAX-1:0] hold;
  } step_t;

  // Assemble the STATUS read word
  function automatic logic [31:0] status_word(input logic busy, input logic done,
                                              input logic [3:0] idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_BUSY] = busy;
    w[STAT_DONE] = done;
    w[STAT_IDX_LSB +: 4] = idx;
    return w;
  endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle; the sequencer attaches through the slave modport.
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk,
  input logic presetn
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic                    pslverr;
  logic [DATA_WIDTH-1:0]   prdata;

  modport master (
    input  pclk, presetn, pready, pslverr, prdata,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    input  pclk, presetn, paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb4_gpio_seq.sv
// APB4-programmable GPIO pattern sequencer. Plays a table of (value, hold)
// steps onto seq_out_o, one-shot or looping, and flags completion via irq_o.
module apb4_gpio_seq
  import apb4_gpio_seq_pkg::*;
#(
  parameter int GPIO_NUM   = 32,
  parameter int STEP_NUM   = 8,
  parameter int HOLD_WIDTH = 16
) (
  apb4_if.slave               apb4,
  output logic [GPIO_NUM-1:0] seq_out_o,
  output logic [GPIO_NUM-1:0] seq_oe_o,
  output logic                irq_o
);

  localparam int IW = $clog2(STEP_NUM);

  // Bus decode
  logic       wr_s;
  logic       rd_s;
  logic [3:0] sel_s;
  logic       start_s;
  logic       stop_s;
  logic       status_rd_s;
  logic       unused_s;

  // Software-visible registers
  logic                loop_r;
  logic                irqen_r;
  logic                done_r;
  logic [GPIO_NUM-1:0] mask_r;
  logic [IW-1:0]       last_r;
  logic [IW-1:0]       idx_r;
  step_t               tbl_r [STEP_NUM];

  // Playback state
  seq_state_e          state_r;
  seq_state_e          state_nxt_s;
  logic [IW-1:0]       step_idx_r;
  logic [HOLD_WIDTH-1:0] cnt_r;
  logic [GPIO_NUM-1:0] out_r;

  // FSM actions
  logic          busy_s;
  logic          cnt_zero_s;
  logic          at_last_s;
  logic          load_s;
  logic [IW-1:0] load_idx_s;
  logic          dec_s;
  logic          done_set_s;
  logic          done_clr_s;
  logic [31:0]   rdata_s;

  assign wr_s        = apb4.psel & apb4.penable & apb4.pwrite;
  assign rd_s        = apb4.psel & apb4.penable & ~apb4.pwrite;
  assign sel_s       = apb4.paddr[5:2];
  assign start_s     = wr_s & (sel_s == REG_CTRL) & apb4.pwdata[CTRL_START];
  assign stop_s      = wr_s & (sel_s == REG_CTRL) & apb4.pwdata[CTRL_STOP];
  assign status_rd_s = rd_s & (sel_s == REG_STATUS);

  assign busy_s     = (state_r == ST_RUN);
  assign cnt_zero_s = (cnt_r == HOLD_WIDTH'(0));
  assign at_last_s  = (step_idx_r == last_r);

  // Address bits outside the register window and the protection/strobe
  // qualifiers carry no meaning for this block
  assign unused_s = ^{apb4.paddr[31:6], apb4.paddr[1:0], apb4.pstrb, apb4.pprot};

  // FSM state register
  always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
    if (!apb4.presetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: STOP beats START, START beats the playback schedule
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !stop_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_nxt_s = ST_IDLE;
        end else if (start_s) begin
          state_nxt_s = ST_RUN;
        end else if (cnt_zero_s && at_last_s && !loop_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM actions: which step to load, counter decrement, completion
  always_comb begin
    load_s     = 1'b0;
    load_idx_s = IW'(0);
    dec_s      = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !stop_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          load_s = 1'b0;
        end else if (start_s) begin
          load_s = 1'b1;
        end else if (!cnt_zero_s) begin
          dec_s = 1'b1;
        end else if (!at_last_s) begin
          load_s     = 1'b1;
          load_idx_s = step_idx_r + IW'(1);
        end else if (loop_r) begin
          load_s = 1'b1;
        end else begin
          done_set_s = 1'b1;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // A fresh start and a STATUS read both clear DONE; completion wins over both
  assign done_clr_s = (start_s & ~stop_s) | status_rd_s;

  // Playback datapath: step index, hold counter and the pattern register
  always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
    if (!apb4.presetn) begin
      step_idx_r <= IW'(0);
      cnt_r      <= HOLD_WIDTH'(0);
      out_r      <= {GPIO_NUM{1'b0}};
    end else if (load_s) begin
      step_idx_r <= load_idx_s;
      cnt_r      <= tbl_r[load_idx_s].hold[HOLD_WIDTH-1:0];
      out_r      <= tbl_r[load_idx_s].val[GPIO_NUM-1:0];
    end else if (dec_s) begin
      cnt_r <= cnt_r - HOLD_WIDTH'(1);
    end
  end

  // Sticky completion flag
  always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
    if (!apb4.presetn) begin
      done_r <= 1'b0;
    end else if (done_set_s) begin
      done_r <= 1'b1;
    end else if (done_clr_s) begin
      done_r <= 1'b0;
    end
  end

  // Register and step-table writes; the table is flops so reset clears it
  always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
    if (!apb4.presetn) begin
      loop_r  <= 1'b0;
      irqen_r <= 1'b0;
      mask_r  <= {GPIO_NUM{1'b0}};
      last_r  <= IW'(0);
      idx_r   <= IW'(0);
      for (int i = 0; i < STEP_NUM; i++) begin
        tbl_r[i].val  <= 32'h0000_0000;
        tbl_r[i].hold <= 32'h0000_0000;
      end
    end else if (wr_s) begin
      case (sel_s)
        REG_CTRL: begin
          loop_r  <= apb4.pwdata[CTRL_LOOP];
          irqen_r <= apb4.pwdata[CTRL_IRQEN];
        end
        REG_MASK: mask_r <= apb4.pwdata[GPIO_NUM-1:0];
        REG_LAST: last_r <= apb4.pwdata[IW-1:0];
        REG_IDX:  idx_r  <= apb4.pwdata[IW-1:0];
        REG_VAL:  tbl_r[idx_r].val  <= apb4.pwdata;
        REG_HOLD: tbl_r[idx_r].hold <= HOLD_WIDTH_MAX'(apb4.pwdata[HOLD_WIDTH-1:0]);
        default: begin
        end
      endcase
    end
  end

  // Read mux, combinational during the access phase
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sel_s)
      REG_CTRL: begin
        rdata_s[CTRL_LOOP]  = loop_r;
        rdata_s[CTRL_IRQEN] = irqen_r;
      end
      REG_STATUS: rdata_s = status_word(busy_s, done_r, 4'(step_idx_r));
      REG_MASK:   rdata_s = 32'(mask_r);
      REG_LAST:   rdata_s = 32'(last_r);
      REG_IDX:    rdata_s = 32'(idx_r);
      REG_VAL:    rdata_s = tbl_r[idx_r].val;
      REG_HOLD:   rdata_s = tbl_r[idx_r].hold;
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  assign apb4.prdata  = rdata_s;
  assign apb4.pready  = 1'b1;
  assign apb4.pslverr = 1'b0;

  assign seq_out_o = out_r;
  assign seq_oe_o  = mask_r & {GPIO_NUM{busy_s}};
  assign irq_o     = done_r & irqen_r;

endmodule
